// File: rtl/skew_rd_ctrl.sv
// Skewed read sequencer for the banked input memory feeding the systolic array.
// Bank 0 reads base..base+num_rows-1; every further bank repeats that run one
// issue step later, so the banks present a diagonal wavefront. A stall freezes
// the issue counter and the skew chain and drops all enables for that step.
module skew_rd_ctrl #(
    parameter int unsigned width_height = 4,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    input  logic [ADDR_W-1:0]                num_rows,
    input  logic                             stall,
    output logic                             busy,
    output logic                             done,
    output logic [width_height-1:0]          rd_en,
    output logic [width_height*ADDR_W-1:0]   rd_addr,
    output logic [width_height-1:0]          data_valid
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [ADDR_W-1:0] k_q, k_d;

    // Skew chain: element i holds the last issued (en, addr) of bank i. It only
    // moves on non-stalled steps; rd_en is the chain enable gated by stall.
    logic [width_height-1:0]             chain_en_q, chain_en_d;
    logic [width_height-1:0][ADDR_W-1:0] chain_addr_q, chain_addr_d;

    logic [width_height-1:0] rd_en_q, rd_en_d;
    logic [width_height-1:0] dv_q;
    logic                    busy_q, done_q;
    logic                    issue;

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = chain_addr_q;
    assign data_valid = dv_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FIN is entered on the edge after the last bank's last enable.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_rows == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (!stall && (k_q == num_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (rd_en_q[width_height-1] && (chain_en_q[width_height-2:0] == '0)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values for the counter, skew chain and registered outputs.
    always_comb begin
        base_d       = base_q;
        num_d        = num_q;
        k_d          = k_q;
        chain_en_d   = chain_en_q;
        chain_addr_d = chain_addr_q;
        rd_en_d      = '0;
        issue        = (state_q == StRun) && (k_q != num_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d          = base_addr;
                    num_d           = num_rows;
                    k_d             = 8'd1;
                    chain_en_d      = {{(width_height-1){1'b0}}, (num_rows != '0)};
                    chain_addr_d[0] = base_addr;
                    rd_en_d         = chain_en_d;
                end
            end
            StRun, StDrain: begin
                if (!stall) begin
                    chain_en_d      = {chain_en_q[width_height-2:0], issue};
                    chain_addr_d[0] = base_q + k_q;
                    for (int i = 1; i < width_height; i++) begin
                        chain_addr_d[i] = chain_addr_q[i-1];
                    end
                    if (issue) begin
                        k_d = k_q + 8'd1;
                    end
                    rd_en_d = chain_en_d;
                end
            end
            StFin: begin
                chain_en_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q       <= '0;
            num_q        <= '0;
            k_q          <= '0;
            chain_en_q   <= '0;
            chain_addr_q <= '0;
            rd_en_q      <= '0;
            dv_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            base_q       <= base_d;
            num_q        <= num_d;
            k_q          <= k_d;
            chain_en_q   <= chain_en_d;
            chain_addr_q <= chain_addr_d;
            rd_en_q      <= rd_en_d;
            dv_q         <= rd_en_q;
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StFin);
        end
    end

endmodule

// File: tb/tb_skew_rd_ctrl.sv
// Bench for skew_rd_ctrl: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a step-count reference model.
module tb_skew_rd_ctrl;

    localparam int W = 4;

    typedef logic [W-1:0][7:0] addr_vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [7:0]     base_addr;
    logic [7:0]     num_rows;
    logic           stall;
    logic           busy;
    logic           done;
    logic [W-1:0]   rd_en;
    logic [W*8-1:0] rd_addr;
    logic [W-1:0]   data_valid;

    int errs   = 0;
    int checks = 0;

    skew_rd_ctrl #(.width_height(W), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: step t counts non-stalled issue steps (t=1 first).
    // At step t bank i reads row j=t-1-i when 0<=j<num.
    function automatic logic [W-1:0] fen(input int t, input int n);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            v[i] = (t - 1 - i >= 0) && (t - 1 - i < n);
        end
        return v;
    endfunction

    function automatic addr_vec_t fad(input int t, input int b, input int n, input addr_vec_t old);
        addr_vec_t v;
        v = old;
        for (int i = 0; i < W; i++) begin
            if ((t - 1 - i >= 0) && (t - 1 - i < n)) v[i] = 8'((b + t - 1 - i) % 256);
        end
        return v;
    endfunction

    logic      m_act, m_fin;
    int        m_base, m_num, m_t;
    logic [W-1:0] e_en, e_dv;
    addr_vec_t e_addr;
    logic      e_busy, e_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act <= 0; m_fin <= 0; m_base <= 0; m_num <= 0; m_t <= 0;
            e_en <= '0; e_dv <= '0; e_addr <= '0; e_busy <= 0; e_done <= 0;
        end else begin
            e_dv <= e_en;
            if (m_fin) begin
                m_fin <= 0; m_act <= 0; e_busy <= 0; e_done <= 0; e_en <= '0;
            end else if (!m_act) begin
                if (start) begin
                    m_base <= int'(base_addr);
                    m_num  <= int'(num_rows);
                    e_busy <= 1;
                    if (num_rows == 0) begin
                        m_fin <= 1; e_done <= 1; e_en <= '0;
                    end else begin
                        m_act  <= 1;
                        m_t    <= 1;
                        e_en   <= fen(1, int'(num_rows));
                        e_addr <= fad(1, int'(base_addr), int'(num_rows), e_addr);
                    end
                end
            end else if (e_en[W-1] && (m_t == m_num + W - 1)) begin
                m_fin <= 1; e_done <= 1; e_en <= '0;
            end else if (stall) begin
                e_en <= '0;
            end else begin
                m_t    <= m_t + 1;
                e_en   <= fen(m_t + 1, m_num);
                e_addr <= fad(m_t + 1, m_base, m_num, e_addr);
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("rd_en", rd_en, e_en);
            chk("data_valid", data_valid, e_dv);
            for (int i = 0; i < W; i++) begin
                if (e_en[i]) chk($sformatf("rd_addr[%0d]", i), rd_addr[i*8 +: 8], e_addr[i]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the negedge of cycle S; returns at the negedge of cycle S+1.
    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        start = 1'b1; base_addr = b; num_rows = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0; num_rows = '0;
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_addr", rd_addr, 0);
        reset = 1'b0;
        tick();

        // Basic skew: base 0x10, 3 rows.
        do_start(8'h10, 8'd3);
        chk("basic_en_s1", rd_en, 4'b0001);
        chk("basic_a0_s1", rd_addr[7:0], 8'h10);
        tick(); tick();
        chk("basic_a0_s3", rd_addr[7:0], 8'h12);
        tick();
        chk("basic_en3_s4", rd_en[3], 1);
        chk("basic_a3_s4", rd_addr[31:24], 8'h10);
        tick(); tick(); tick();
        chk("basic_done_s7", done, 1);
        chk("basic_dv3_s7", data_valid[3], 1);
        tick();
        chk("basic_busy_s8", busy, 0);
        tick();

        // Wrap-around.
        do_start(8'hFE, 8'd4);
        tick(); tick();
        chk("wrap_a0_s3", rd_addr[7:0], 8'h00);
        repeat (8) tick();

        // Two-cycle stall starting at S+3.
        do_start(8'h00, 8'd4);
        tick(); tick();
        stall = 1'b1;
        tick();
        chk("stall_en_s4", rd_en, 0);
        tick();
        stall = 1'b0;
        chk("stall_en_s5", rd_en, 0);
        repeat (5) tick();
        chk("stall_done_s10", done, 1);
        repeat (2) tick();

        // Zero rows, then an immediate restart.
        do_start(8'h55, 8'd0);
        chk("zero_busy_s1", busy, 1);
        chk("zero_done_s1", done, 1);
        chk("zero_en_s1", rd_en, 0);
        tick();
        do_start(8'h33, 8'd1);
        chk("restart_en", rd_en, 4'b0001);
        chk("restart_a0", rd_addr[7:0], 8'h33);
        repeat (7) tick();

        // Start while busy is ignored.
        do_start(8'h20, 8'd5);
        tick();
        start = 1'b1; base_addr = 8'h80; num_rows = 8'd9;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ign_a3_s8", rd_addr[31:24], 8'h24);
        repeat (2) tick();
        chk("ign_busy_s10", busy, 0);
        tick();

        // Asynchronous reset mid-run.
        do_start(8'h40, 8'd6);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_en", rd_en, 0);
        chk("areset_dv", data_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        do_start(8'h05, 8'd2);
        chk("post_en", rd_en, 4'b0001);
        chk("post_a0", rd_addr[7:0], 8'h05);
        repeat (5) tick();
        chk("post_done", done, 1);
        tick();

        // Randomized traffic, including start during busy/done and random stalls.
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom % 8 == 0);
            base_addr = 8'($urandom);
            num_rows  = ($urandom % 8 == 0) ? 8'($urandom % 64) : 8'($urandom % 6);
            stall     = ($urandom % 5 == 0);
            tick();
        end
        start = 1'b0; stall = 1'b0;
        repeat (80) tick();
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/skew_rd_ctrl.md
Name: skew_rd_ctrl

Overview:
- Read sequencer for the banked input memory array: width_height independent 8-bit-address banks, each with its own rd_en and rd_addr.
- On a start request, it issues a run of consecutive addresses to every bank. Bank i lags bank i-1 by exactly one cycle, giving the diagonal skew that feeds the systolic array.
- It also generates per-bank data-valid strobes aligned to the 1-cycle memory read latency, and a completion pulse.
- It sits between the TPU top-level control FSM and the memory array's read ports.

Parameters:
- width_height, 4, number of banks; also the systolic array dimension.
- ADDR_W, 8, per-bank address width. Fixed to 8 to match the bank address fields; not to be overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a read sequence; sampled only in IDLE
- base_addr  input  8  first address read from every bank
- num_rows  input  8  addresses per bank, 0..255
- stall  input  1  freeze sequencing while high
- busy  output  1  high while a sequence is in progress
- done  output  1  one-cycle pulse when the last bank's last data is valid
- rd_en  output  width_height  per-bank read enable, bit i goes to bank i
- rd_addr  output  width_height*8  per-bank read address, bits [8i+7:8i] go to bank i
- data_valid  output  width_height  rd_en delayed 1 cycle; marks valid rd_data per bank

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rd_en, rd_addr, data_valid all 0; counters cleared. A reset mid-sequence abandons it with no done pulse.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 latches base_addr and num_rows. If num_rows=0, go to FIN; else go to RUN.
  - RUN: the bank-0 issue counter k runs 0..num_rows-1.
  - DRAIN: waits for the skew pipeline to empty and for the final data_valid.
  - FIN: single cycle; done=1, then back to IDLE.
- Bank 0 generation: in RUN with stall=0, rd_en[0]=1 and rd_addr[0]=base+k, then k increments. Address arithmetic is mod 256, so wrap-around is silent (0xFF -> 0x00).
- Skew pipeline: bank i's enable/address equals bank i-1's from the previous non-stalled cycle. Implement as a shift chain of (en, addr).
- Timing without stall, start sampled in cycle S:
  - rd_en[i] high for cycles S+1+i .. S+num_rows+i.
  - data_valid[i] high for cycles S+2+i .. S+num_rows+1+i.
  - done pulses at cycle S+num_rows+width_height, the same cycle as the final data_valid[width_height-1].
  - busy=1 from S+1 through the done cycle inclusive.
- Sequence length: RUN lasts num_rows cycles; the sequence completes in num_rows+width_height cycles total.
- num_rows=0: busy=1 and done=1 in cycle S+1 only. No rd_en is ever asserted.
- stall=1 (in RUN or DRAIN):
  - All rd_en forced 0 that cycle.
  - Counter k and the skew chain hold their values.
  - data_valid follows the gated rd_en, so it is 0 in the cycle after a stall.
  - Relative skew between banks is preserved.
  - stall in IDLE or FIN has no effect.
- start while busy: ignored; latched parameters are unchanged.
- start in the same cycle as done: ignored. A new start is accepted from the cycle after done.
- rd_addr of a disabled bank: holds its last value (don't-care to the memory). The bench checks it only where rd_en=1.

Test Plan:
- Basic skew, width_height=4, base=0x10, num_rows=3, start at S:
  - rd_en[0] at S+1..S+3 with addresses 0x10, 0x11, 0x12.
  - rd_en[3] at S+4..S+6 with the same addresses.
  - data_valid[3] at S+5..S+7; done at S+7; busy low at S+8.
- Wrap-around, base=0xFE, num_rows=4: each bank reads 0xFE, 0xFF, 0x00, 0x01 in order; no stray enables.
- Stall, base=0x00, num_rows=4, stall high for 2 cycles at S+3:
  - All rd_en=0 during the stall.
  - Bank address sequences are unchanged; the 1-cycle inter-bank skew is kept.
  - done is delayed by 2, landing at S+10.
- num_rows=0: busy and done high at S+1 only; rd_en stays 0; second start at S+2 is accepted.
- start pulsed at S+2 during a base=0x20, num_rows=5 run with base=0x80: ignored; all addresses stay in 0x20..0x24.
- Reset asserted asynchronously mid-RUN (S+3, between clock edges):
  - All outputs go to 0 immediately, with no done pulse.
  - After release, start with base=0x05, num_rows=2 behaves as in a fresh sequence.
